cdb_kport_arbiter: RTL
======================

Name: cdb_kport_arbiter

Overview:
- Next-generation Common Data Bus arbiter with built-in broadcast registers.
- Arbitrates N functional-unit producers onto K parallel CDB channels, where K is a parameter rather than the fixed two channels of the previous generation.
- Adds rotating-pointer fairness, a starvation guard and a flush.
- Sits between the FU writeback stage and the reservation stations and ROB.

Parameters:
- N, 4: number of producers (functional units); must be >= 2.
- K, 2: number of CDB broadcast channels; 1 <= K <= N.
- DATA_W, 32: result data width.
- TAG_W, 5: destination tag width.
- STARVE_LIMIT, 3: cycles a request may wait ungranted before it becomes urgent; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (mispredict or exception).
- req  in  N  per-producer request; held high until granted.
- data_in  in  N x DATA_W  per-producer result.
- tag_in  in  N x TAG_W  per-producer destination tag.
- exc_in  in  N  per-producer exception flag.
- grant  out  N  combinational, same-cycle grant; at most K bits set.
- cdb_valid  out  K  registered channel valid.
- cdb_data  out  K x DATA_W  registered channel data.
- cdb_tag  out  K x TAG_W  registered channel tag.
- cdb_exc  out  K  registered channel exception flag.
- cdb_src  out  K x clog2(N)  registered index of the producer driving each channel.

Behaviour:
- Reset (asynchronous, active-high, applies at any time including mid-operation):
  - cdb_valid, cdb_data, cdb_tag, cdb_exc, cdb_src all 0.
  - ptr = 0.
  - All wait counters = 0.
  - grant = 0 while rst is high.
- Handshake:
  - A producer drives req with stable data_in, tag_in and exc_in.
  - grant[i] high in cycle t means producer i is consumed at the clk edge ending cycle t.
  - The producer may drop req or present new data in cycle t+1.
  - req high with grant low: the producer must hold its data.
- Latency: a grant in cycle t makes cdb_valid and the payload visible in cycle t+1. Throughput is up to K results per cycle.
- Selection, combinational each cycle:
  - Urgent set = req & (wait_cnt == STARVE_LIMIT).
  - Pass 1: grant urgent producers in rotated order starting at ptr, up to K.
  - Pass 2: fill the remaining channels with non-urgent requesters in rotated order starting at ptr.
  - Channel j receives the j-th grant in issue order: urgent first, then rotated order.
  - Channels that receive no grant get cdb_valid[j] = 0 next cycle; their payload registers hold.
- Pointer update:
  - If any grant was issued: ptr_next = (rotated position of the last-issued grant in rotated order + ptr + 1) mod N. Wrap from N-1 goes to 0.
  - No grant: ptr holds.
- Wait counters (one per producer, width clog2(STARVE_LIMIT+1)):
  - req[i] & !grant[i]: increment, saturating at STARVE_LIMIT.
  - grant[i] or !req[i]: clear to 0.
- Flush:
  - grant = 0 that cycle.
  - cdb_valid = 0 next cycle.
  - Wait counters cleared; ptr holds.
  - Flush overrides urgency.
  - Flush together with rst: rst dominates.
- Boundaries:
  - All N requesting with K < N: exactly K grants issued.
  - Zero requests: cdb_valid all 0, no state change except counters clearing.
  - K == N: every requester is granted each cycle; counters stay 0.
  - Guarantee: no request waits more than STARVE_LIMIT + ceil(N/K) cycles.

Optional Feature:
- Macro: CDB_PERF_EN.
- Defined:
  - Adds outputs perf_grants (32 bits, total grants issued) and perf_conflicts (32 bits, cycles where popcount(req) > K).
  - Both wrap at 2^32 and reset to 0 on rst only; flush does not clear them.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package cdb_pkg holds:
  - CDB_DATA_W = 32 and CDB_TAG_W = 5 default constants.
  - typedef cdb_pkt_t, a struct of data, tag and exc.
  - function popcount.
- Sub-module cdb_rr_pick:
  - Combinational.
  - Inputs: N-bit mask and ptr.
  - Outputs: up to K one-hot picks in rotated order, plus the rotated position of the last pick.
  - Instantiated twice: urgent pass and fill pass.

Test Plan:
- Reset and idle: rst pulsed mid-traffic with N=4, K=2 -> next edge all cdb_valid=0, ptr=0, grant=0 during reset.
- Full contention: req=4'b1111 held for 4 cycles, ptr=0 -> grants {0,1}, {2,3}, {0,1}, {2,3}; cdb_src matches one cycle later.
- Wrap-around: ptr=3, req=4'b1001 -> grant channel0=3, channel1=0; ptr_next=1.
- Starvation: N=4, K=1, STARVE_LIMIT=2; producers 0,1,2 always requesting, producer 3 requests from cycle 0 -> producer 3 granted no later than cycle 3.
- Flush: req=4'b0110 with flush=1 -> grant=0, next cycle cdb_valid=0, counters cleared, ptr unchanged; same requests granted the following cycle.
- Payload integrity: producer 2 presents data=0xDEADBEEF, tag=5'd17, exc=1 -> the channel with cdb_src=2 shows exactly those values one cycle after grant.

Source files
------------

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants, payload struct and popcount helper for the CDB arbiter
package cdb_pkg;

    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 5;

    // One broadcast payload as seen by reservation stations and the ROB
    typedef struct packed {
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_TAG_W-1:0]  tag;
        logic                  exc;
    } cdb_pkt_t;

    // Number of set bits; callers zero-extend narrower vectors to 64 bits
    function automatic int popcount(input logic [63:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// rtl/cdb_rr_pick.sv - combinational rotated-priority picker returning up to K one-hot picks
module cdb_rr_pick #(
    parameter  int N  = 4,
    parameter  int K  = 2,
    localparam int PW = $clog2(N),
    localparam int CW = $clog2(K + 1)
) (
    input  logic [N-1:0]   mask,
    input  logic [PW-1:0]  ptr,
    input  logic [CW-1:0]  limit,
    output logic [K*N-1:0] pick,
    output logic [CW-1:0]  count,
    output logic [PW-1:0]  last_pos
);

    logic [2*N-1:0] mask_dbl;
    logic [N-1:0]   mask_rot;
    logic [K*N-1:0] pick_rot;
    logic [2*N-1:0] pick_dbl;

    // Rotate the mask so bit r is producer (ptr + r) mod N
    always_comb begin
        mask_dbl = {mask, mask} >> ptr;
        mask_rot = mask_dbl[N-1:0];
    end

    // Walk rotated positions in order, handing out picks until the limit is reached
    always_comb begin
        pick_rot = '0;
        count    = '0;
        last_pos = '0;
        for (int r = 0; r < N; r++) begin
            if (mask_rot[r] && (count < limit)) begin
                for (int j = 0; j < K; j++) begin
                    if (count == CW'(j)) pick_rot[j*N + r] = 1'b1;
                end
                last_pos = PW'(r);
                count    = count + CW'(1);
            end
        end
    end

    // Rotate each pick back into producer index space
    always_comb begin
        pick     = '0;
        pick_dbl = '0;
        for (int j = 0; j < K; j++) begin
            pick_dbl         = {pick_rot[j*N +: N], pick_rot[j*N +: N]} << ptr;
            pick[j*N +: N]   = pick_dbl[2*N-1:N];
        end
    end

endmodule

// File: rtl/cdb_kport_arbiter.sv
// rtl/cdb_kport_arbiter.sv - N-producer to K-channel CDB arbiter with starvation guard; CDB_PERF_EN adds perf counters
module cdb_kport_arbiter
    import cdb_pkg::*;
#(
    parameter int N            = 4,
    parameter int K            = 2,
    parameter int DATA_W       = CDB_DATA_W,
    parameter int TAG_W        = CDB_TAG_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [N-1:0]              req,
    input  logic [N*DATA_W-1:0]       data_in,
    input  logic [N*TAG_W-1:0]        tag_in,
    input  logic [N-1:0]              exc_in,
    output logic [N-1:0]              grant,
    output logic [K-1:0]              cdb_valid,
    output logic [K*DATA_W-1:0]       cdb_data,
    output logic [K*TAG_W-1:0]        cdb_tag,
    output logic [K-1:0]              cdb_exc,
`ifdef CDB_PERF_EN
    output logic [31:0]               perf_grants,
    output logic [31:0]               perf_conflicts,
`endif
    output logic [K*$clog2(N)-1:0]    cdb_src
);

    localparam int PW  = $clog2(N);
    localparam int PW1 = PW + 1;
    localparam int WW  = $clog2(STARVE_LIMIT + 1);
    localparam int CW  = $clog2(K + 1);

    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N*WW-1:0]     wait_q, wait_d;
    logic [K-1:0]        cdb_valid_q, cdb_valid_d;
    logic [K*DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [K*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [K-1:0]        cdb_exc_q, cdb_exc_d;
    logic [K*PW-1:0]     cdb_src_q, cdb_src_d;

    logic [N-1:0]        urgent, fill_mask, grant_int;
    logic [K*N-1:0]      u_pick, f_pick, chan_oh;
    logic [CW-1:0]       u_cnt, f_cnt, f_limit;
    logic [PW-1:0]       u_last, f_last, max_pos;
    logic [K-1:0]        chan_vld;
    logic [K*PW-1:0]     chan_src;
    logic [PW:0]         ptr_sum;

    // A requester becomes urgent once its wait counter has saturated
    always_comb begin
        urgent = '0;
        for (int i = 0; i < N; i++) begin
            urgent[i] = req[i] && (wait_q[i*WW +: WW] == WW'(STARVE_LIMIT));
        end
    end

    assign fill_mask = req & ~urgent;
    assign f_limit   = CW'(K) - u_cnt;

    cdb_rr_pick #(.N(N), .K(K)) u_urgent_pick (
        .mask     (urgent),
        .ptr      (ptr_q),
        .limit    (CW'(K)),
        .pick     (u_pick),
        .count    (u_cnt),
        .last_pos (u_last)
    );

    cdb_rr_pick #(.N(N), .K(K)) u_fill_pick (
        .mask     (fill_mask),
        .ptr      (ptr_q),
        .limit    (f_limit),
        .pick     (f_pick),
        .count    (f_cnt),
        .last_pos (f_last)
    );

    // Channels take urgent picks first, then fill picks; flush suppresses all grants
    always_comb begin
        chan_oh = '0;
        if (!flush) begin
            for (int j = 0; j < K; j++) begin
                if (j < int'(u_cnt)) begin
                    chan_oh[j*N +: N] = u_pick[j*N +: N];
                end else begin
                    for (int m = 0; m < K; m++) begin
                        if (int'(u_cnt) + m == j) chan_oh[j*N +: N] = f_pick[m*N +: N];
                    end
                end
            end
        end
    end

    // Per-channel valid, source index and the merged grant vector
    always_comb begin
        grant_int = '0;
        chan_vld  = '0;
        chan_src  = '0;
        for (int j = 0; j < K; j++) begin
            grant_int   = grant_int | chan_oh[j*N +: N];
            chan_vld[j] = |chan_oh[j*N +: N];
            for (int i = 0; i < N; i++) begin
                if (chan_oh[j*N + i]) chan_src[j*PW +: PW] = PW'(i);
            end
        end
    end

    assign grant = rst ? '0 : grant_int;

    // Pointer advances past the granted producer furthest along in rotated order
    always_comb begin
        if (f_cnt != '0 && (u_cnt == '0 || f_last > u_last)) max_pos = f_last;
        else                                                  max_pos = u_last;
        ptr_sum = {1'b0, ptr_q} + {1'b0, max_pos} + PW1'(1);
        ptr_d   = ptr_q;
        if (|grant_int) begin
            ptr_d = (ptr_sum >= PW1'(N)) ? PW'(ptr_sum - PW1'(N)) : PW'(ptr_sum);
        end
    end

    // Load channel payloads from granted producers; idle channels keep their payload
    always_comb begin
        cdb_valid_d = chan_vld;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_exc_d   = cdb_exc_q;
        cdb_src_d   = cdb_src_q;
        for (int j = 0; j < K; j++) begin
            if (chan_vld[j]) begin
                cdb_src_d[j*PW +: PW] = chan_src[j*PW +: PW];
                for (int i = 0; i < N; i++) begin
                    if (chan_oh[j*N + i]) begin
                        cdb_data_d[j*DATA_W +: DATA_W] = data_in[i*DATA_W +: DATA_W];
                        cdb_tag_d[j*TAG_W +: TAG_W]    = tag_in[i*TAG_W +: TAG_W];
                        cdb_exc_d[j]                   = exc_in[i];
                    end
                end
            end
        end
    end

    // Wait counters count consecutive ungranted request cycles, saturating at the limit
    always_comb begin
        wait_d = '0;
        for (int i = 0; i < N; i++) begin
            if (flush || !req[i] || grant_int[i]) begin
                wait_d[i*WW +: WW] = '0;
            end else if (wait_q[i*WW +: WW] == WW'(STARVE_LIMIT)) begin
                wait_d[i*WW +: WW] = wait_q[i*WW +: WW];
            end else begin
                wait_d[i*WW +: WW] = wait_q[i*WW +: WW] + WW'(1);
            end
        end
    end

    // Arbiter state and registered broadcast channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            wait_q      <= '0;
            cdb_valid_q <= '0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_exc_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_exc_q   <= cdb_exc_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_exc   = cdb_exc_q;
    assign cdb_src   = cdb_src_q;

`ifdef CDB_PERF_EN
    logic [31:0] perf_grants_q, perf_grants_d;
    logic [31:0] perf_conflicts_q, perf_conflicts_d;

    // Grant total and oversubscribed-cycle count; only reset clears them
    always_comb begin
        perf_grants_d    = perf_grants_q + 32'(popcount(64'(grant_int)));
        perf_conflicts_d = perf_conflicts_q;
        if (popcount(64'(req)) > K) perf_conflicts_d = perf_conflicts_q + 32'd1;
    end

    // Performance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_grants_q    <= '0;
            perf_conflicts_q <= '0;
        end else begin
            perf_grants_q    <= perf_grants_d;
            perf_conflicts_q <= perf_conflicts_d;
        end
    end

    assign perf_grants    = perf_grants_q;
    assign perf_conflicts = perf_conflicts_q;
`endif

endmodule
